// File: rtl/period_meas_avg.sv
// period_meas_avg: measures the interval between accepted rising edges of sig_in,
// scales it to OUT_W bits and smooths it with a 2^AVG_LOG moving average.
module period_meas_avg #(
    parameter int CNT_W     = 24,
    parameter int TIMEOUT   = 24'hE4E1C0,
    parameter int OUT_SHIFT = 16,
    parameter int OUT_W     = 8,
    parameter int AVG_LOG   = 2,
    parameter int MIN_PER   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clr,
    output logic [OUT_W-1:0] period,
    output logic             period_vld,
    output logic             stalled
);
    localparam int DEPTH = 1 << AVG_LOG;
    localparam int PW    = AVG_LOG > 0 ? AVG_LOG : 1;
    localparam int SW    = OUT_W + AVG_LOG;
    localparam int OMAX  = (1 << OUT_W) - 1;
    localparam int TSI   = (TIMEOUT >> OUT_SHIFT) > OMAX ? OMAX : (TIMEOUT >> OUT_SHIFT);
    localparam logic [OUT_W-1:0] TS = OUT_W'(TSI);
    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
    localparam logic [1:0] ST_STALL = 2'd0, ST_ARMED = 2'd1, ST_RUN = 2'd2;

    logic             prev, rise, long_enough, acc, tmo, flush, push;
    logic [CNT_W-1:0] cnt, cnt_sh;
    logic [1:0]       state, state_n;
    logic [OUT_W-1:0] s, fval;
    logic [OUT_W-1:0] buf_q [DEPTH];
    logic [PW-1:0]    ptr;
    logic [SW-1:0]    sum, sum_push;

    generate
        if (MIN_PER == 0) begin : g_nomin
            assign long_enough = 1'b1;
        end else begin : g_min
            assign long_enough = cnt >= CNT_W'(MIN_PER);
        end
    endgenerate

    always_comb begin
        rise     = sig_in & ~prev;
        acc      = rise & long_enough;
        tmo      = ~acc & (cnt == TO - 1'b1);
        cnt_sh   = cnt >> OUT_SHIFT;
        s        = (32'(cnt_sh) > 32'(OMAX)) ? OUT_W'(OMAX) : OUT_W'(cnt_sh);
        // the first period after a stall pre-loads the whole window so the output steps
        flush    = clr | (acc & (state == ST_ARMED)) | (tmo & (state == ST_RUN));
        fval     = (~clr & acc) ? s : TS;
        push     = ~clr & acc & (state == ST_RUN);
        sum_push = sum - SW'(buf_q[ptr]) + SW'(s);
        state_n  = clr ? ST_STALL :
                   acc ? ((state == ST_STALL) ? ST_ARMED : ST_RUN) :
                   tmo ? ST_STALL : state;
    end

    assign stalled = (state != ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= 1'b0;
            cnt        <= CNT_W'(1);
            state      <= ST_STALL;
            period_vld <= 1'b0;
        end else begin
            prev       <= sig_in;
            cnt        <= (clr | acc) ? CNT_W'(1) : (cnt == TO) ? cnt : cnt + 1'b1;
            state      <= state_n;
            period_vld <= ~clr & ((acc & (state != ST_STALL)) | (tmo & (state == ST_RUN)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= TS;
            sum    <= SW'(TS) << AVG_LOG;
            ptr    <= '0;
            period <= TS;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= fval;
            sum    <= SW'(fval) << AVG_LOG;
            ptr    <= '0;
            period <= fval;
        end else if (push) begin
            buf_q[ptr] <= s;
            sum        <= sum_push;
            ptr        <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
            period     <= OUT_W'(sum_push >> AVG_LOG);
        end
    end
endmodule

// File: tb/tb_period_meas_avg.sv
// tb_period_meas_avg: directed and random pulse trains checked every cycle against
// a queue-based model of the period measurement and moving average.
module tb_period_meas_avg;
    localparam int CNT_W = 16, TIMEOUT = 1000, OUT_SHIFT = 2, OUT_W = 8;
    localparam int AVG_LOG = 2, MIN_PER = 20, DEPTH = 4, TS = 250;

    logic       clk = 1'b0, rst_n = 1'b0, sig_in = 1'b0, clr = 1'b0;
    logic [7:0] period;
    logic       period_vld, stalled;

    period_meas_avg #(
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .OUT_SHIFT(OUT_SHIFT),
        .OUT_W(OUT_W), .AVG_LOG(AVG_LOG), .MIN_PER(MIN_PER)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .clr(clr),
        .period(period), .period_vld(period_vld), .stalled(stalled)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int since, mode, exp_period, exp_vld, exp_stalled;
    bit mprev;
    int q[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int v);
        q.delete();
        repeat (DEPTH) q.push_back(v);
    endtask

    task automatic model_reset();
        since = 1; mode = 0; mprev = 0;
        fill(TS);
        exp_period = TS; exp_vld = 0; exp_stalled = 1;
    endtask

    // mode: 0 = stalled, 1 = armed, 2 = running
    task automatic model_step(input bit s, input bit c);
        bit acc, tmo;
        int smp, tot;
        acc = s && !mprev && since >= MIN_PER;
        tmo = !acc && since == TIMEOUT - 1;
        smp = (since >> OUT_SHIFT) > 255 ? 255 : (since >> OUT_SHIFT);
        exp_vld = 0;
        if (c) begin
            mode = 0; fill(TS); exp_period = TS; since = 1;
        end else begin
            if (acc && mode == 0) mode = 1;
            else if (acc && mode == 1) begin
                mode = 2; fill(smp); exp_period = smp; exp_vld = 1;
            end else if (acc) begin
                void'(q.pop_front());
                q.push_back(smp);
                tot = 0;
                foreach (q[i]) tot += q[i];
                exp_period = tot / DEPTH; exp_vld = 1;
            end else if (tmo && mode == 2) begin
                mode = 0; fill(TS); exp_period = TS; exp_vld = 1;
            end else if (tmo) mode = 0;
            since = acc ? 1 : (since < TIMEOUT ? since + 1 : TIMEOUT);
        end
        mprev = s;
        exp_stalled = (mode != 2);
    endtask

    task automatic tick(input bit s, input bit c);
        sig_in = s; clr = c;
        @(posedge clk);
        model_step(s, c);
        #1;
    endtask

    task automatic pulse(input int n);
        repeat (n - 1) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if (int'(period) != exp_period || int'(period_vld) != exp_vld || int'(stalled) != exp_stalled) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t: period=%0d vld=%0d stalled=%0d, expected %0d %0d %0d",
                         $time, period, period_vld, stalled, exp_period, exp_vld, exp_stalled);
            end
        end
    end

    initial begin
        int exp_avg[5] = '{87, 75, 62, 50, 50};
        int r;
        model_reset();
        #22 rst_n = 1'b1;
        chk("rst_period", int'(period), 250);
        chk("rst_stalled", int'(stalled), 1);
        chk("rst_vld", int'(period_vld), 0);
        repeat (5000) tick(1'b0, 1'b0);
        chk("idle_period", int'(period), 250);
        chk("idle_stalled", int'(stalled), 1);
        pulse(1);
        chk("arm_vld", int'(period_vld), 0);
        chk("arm_stalled", int'(stalled), 1);
        pulse(400);
        chk("run_period", int'(period), 100);
        chk("run_vld", int'(period_vld), 1);
        chk("run_stalled", int'(stalled), 0);
        chk("model_run", exp_period, 100);
        tick(1'b0, 1'b0);
        chk("vld_one_cycle", int'(period_vld), 0);
        for (int i = 0; i < 5; i++) begin
            pulse(i == 0 ? 199 : 200);
            chk("avg_period", int'(period), exp_avg[i]);
            chk("avg_vld", int'(period_vld), 1);
        end
        pulse(10);
        chk("glitch_vld", int'(period_vld), 0);
        chk("glitch_period", int'(period), 50);
        pulse(190);
        chk("post_glitch_period", int'(period), 50);
        chk("post_glitch_vld", int'(period_vld), 1);
        repeat (998) tick(1'b0, 1'b0);
        chk("pre_tmo_stalled", int'(stalled), 0);
        tick(1'b0, 1'b0);
        chk("tmo_period", int'(period), 250);
        chk("tmo_stalled", int'(stalled), 1);
        chk("tmo_vld", int'(period_vld), 1);
        pulse(1500);
        chk("rearm_vld", int'(period_vld), 0);
        chk("rearm_stalled", int'(stalled), 1);
        pulse(300);
        chk("rerun_period", int'(period), 75);
        chk("model_rerun", exp_period, 75);
        repeat (299) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        chk("clr_period", int'(period), 250);
        chk("clr_stalled", int'(stalled), 1);
        chk("clr_vld", int'(period_vld), 0);
        pulse(100);
        pulse(100);
        chk("after_clr_period", int'(period), 25);
        chk("after_clr_stalled", int'(stalled), 0);
        repeat (20) tick(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_period", int'(period), 250);
        chk("arst_stalled", int'(stalled), 1);
        chk("arst_vld", int'(period_vld), 0);
        #20 rst_n = 1'b1;
        repeat (60) begin
            r = $urandom_range(0, 9);
            if (r == 0) tick(1'($urandom_range(0, 1)), 1'b1);
            else if (r == 1) repeat ($urandom_range(1000, 1300)) tick(1'b0, 1'b0);
            else begin
                repeat ($urandom_range(1, 420)) tick(1'b0, 1'b0);
                repeat ($urandom_range(1, 4)) tick(1'b1, 1'b0);
            end
        end
        tick(1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/period_meas_avg.md
Name: period_meas_avg

Overview:
- Parametrised successor to the single-channel cadence period timer.
- Measures the clock-cycle interval between accepted rising edges of a filtered, synchronous pulse input (cadence, wheel or hall sensor) and scales it to OUT_W bits.
- Rejects glitch edges shorter than MIN_PER and smooths the result with a 2^AVG_LOG-deep moving average.
- Flags a stall on timeout and pre-loads the averager on the first valid period after a stall, so the output steps rather than ramps. Feeds the torque/assist sensor chain.

Parameters:
- CNT_W, 24, interval counter width.
- TIMEOUT, 24'hE4E1C0, interval in clocks that declares a stall (must be < 2^CNT_W).
- OUT_SHIFT, 16, right shift from counter to output scale.
- OUT_W, 8, output width.
- AVG_LOG, 2, log2 of averaging depth (0 = no averaging).
- MIN_PER, 0, accepted edges must satisfy counter >= MIN_PER (0 disables rejection).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sig_in  in  1  filtered, already-synchronised pulse input
- clr  in  1  synchronous clear to stall state
- period  out  OUT_W  averaged scaled period
- period_vld  out  1  one-cycle pulse when period is updated
- stalled  out  1  no valid period is available (timeout, reset or clr)

Behaviour:
- Derived constant TS = min(TIMEOUT>>OUT_SHIFT, 2^OUT_W-1). Default TS = 8'hE4.
- Edge detect: prev flop (reset 0). rise = sig_in & ~prev.
- Edge acceptance: accepted = rise & (counter >= MIN_PER). Rejected rises have no effect at all.
- Interval counter, CNT_W bits, reset 1:
  - Loads 1 on an accepted rise.
  - Otherwise increments, saturating at TIMEOUT.
  - Counter value in the cycle of a rise therefore equals clocks since the previous accepted rise.
- Sample: s = min(counter>>OUT_SHIFT, 2^OUT_W-1), taken in the cycle of an accepted rise.
- Averager:
  - Circular buffer of 2^AVG_LOG entries, each OUT_W bits, with write pointer and running sum (OUT_W+AVG_LOG bits).
  - Push: sum <= sum - buf[ptr] + s; buf[ptr] <= s; ptr wraps modulo depth.
  - period = new sum >> AVG_LOG (truncating), registered.
  - Flush(v): every entry = v, sum = v<<AVG_LOG, period = v, ptr = 0.
- State machine, three states: STALL, ARMED, RUN.
  - Reset state: STALL, buffer flushed to TS, period = TS, stalled = 1, period_vld = 0.
  - STALL: accepted rise -> ARMED. No output change.
  - ARMED: accepted rise -> RUN; flush(s); stalled <= 0; period_vld pulses.
  - ARMED: timeout -> STALL. No pulse.
  - RUN: accepted rise -> push(s); period_vld pulses.
  - RUN: timeout -> STALL; flush(TS); stalled <= 1; period_vld pulses.
  - Timeout is counter == TIMEOUT-1 with no accepted rise, so it fires exactly TIMEOUT clocks after the last accepted rise.
  - In STALL the counter sits saturated at TIMEOUT.
- Latency: a rise seen in cycle k updates period and stalled, and asserts period_vld, in cycle k+1.
- Priority:
  - clr (any state) forces STALL, flush(TS), stalled = 1, counter = 1, no period_vld.
  - clr beats a simultaneous rise.
  - An accepted rise beats a simultaneous timeout.
- Asynchronous reset mid-operation returns everything to the reset values above, immediately.
- All arithmetic is unsigned. Sum subtraction cannot underflow because sum always equals the sum of the buffer entries.

Test Plan:
Bench parameters: CNT_W=16, TIMEOUT=1000, OUT_SHIFT=2, OUT_W=8, AVG_LOG=2, MIN_PER=20 (TS=250).
1. Reset -> period=250, stalled=1, period_vld=0. Hold sig_in low for 5000 clocks -> no period_vld, no change.
2. Rises every 400 clocks -> first rise gives no pulse. Second rise -> next cycle period=100, stalled=0, period_vld high for exactly 1 cycle.
3. Interval then drops to 200 clocks -> successive period values 87, 75, 62, 50, then steady at 50.
4. Glitch rise 10 clocks after an accepted rise -> ignored, no pulse. Next rise 200 clocks after the real edge -> sample 50.
5. Pulses stop in RUN -> exactly 1000 clocks after the last rise: period=250, stalled=1, one period_vld pulse. A subsequent rise 1500 clocks later re-arms without a pulse.
6. clr asserted in the same cycle as a rise in RUN -> STALL, period=250, stalled=1, no pulse. Also assert rst_n low mid-RUN -> outputs return to reset values asynchronously.
